clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Mode/set controller for the hh:mm:ss time-of-day counter.
- Gates the counter's count enable.
- Captures the current time into shadow registers, lets the user step hour/min/sec with two buttons, and issues a one-cycle load pulse to write the edited time back.
- Abandons an edit after a configurable idle timeout, measured in seconds from a free-running 1 Hz tick.

Parameters:
- TIMEOUT_SEC, 30: idle seconds in any SET state before abort to RUN; legal range 1..255.
- REPEAT_DELAY, 50_000_000: cycles btn_inc must be held before the first auto-increment (AUTO_REPEAT_EN only).
- REPEAT_RATE, 10_000_000: cycles between subsequent auto-increments (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous assert, active-low; all flops clear.
- sec_tick  in  1  1-cycle pulse per second from a free-running generator, independent of cnt_en.
- btn_mode  in  1  mode button level, already synchronized and debounced.
- btn_inc  in  1  increment button level, already synchronized and debounced.
- cur_hour  in  5  live hour from the counter, 0..23.
- cur_min  in  6  live minute, 0..59.
- cur_sec  in  6  live second, 0..59.
- cnt_en  out  1  count enable to the counter.
- load  out  1  1-cycle pulse: counter loads the load_* values.
- load_hour  out  5  shadow hour.
- load_min  out  6  shadow minute.
- load_sec  out  6  shadow second.
- sel  out  2  field being edited: 0=none, 1=hour, 2=min, 3=sec (display blink select).

Behaviour:
- Reset values: state RUN, cnt_en=1, load=0, load_*=0, sel=0, idle counter 0, button history regs 0.
- Button edges: rising edge = level high and registered previous level low. Edge is acted on in the cycle it is detected; response is visible on outputs the next clock.
- States: RUN, SET_HOUR, SET_MIN, SET_SEC.
- Outputs by state: sel = state encoding; cnt_en=1 only in RUN (registered, changes with state).
- RUN, mode edge: go to SET_HOUR; load_hour/min/sec <= cur_hour/min/sec in the same edge; idle counter <= 0.
- RUN, inc edges: ignored.
- SET_x, inc edge: selected shadow field +1 with wrap. Hour 23->0, min/sec 59->0. Other fields unchanged. Idle counter <= 0.
- SET_HOUR, mode edge: go to SET_MIN.
- SET_MIN, mode edge: go to SET_SEC.
- SET_SEC, mode edge: go to RUN and assert load for exactly 1 cycle, the same cycle cnt_en returns to 1.
- Every mode edge in a SET state clears the idle counter.
- Simultaneous mode and inc edges: mode wins; the increment is dropped.
- Timeout, in SET states only: sec_tick increments the idle counter.
  - When the counter reaches TIMEOUT_SEC, go to RUN with no load pulse; the counter keeps its pre-edit time.
  - Shadows keep their edited values; the next RUN->SET recaptures them.
- sec_tick coincident with a button edge: the edge wins, and the counter clears rather than increments.
- Idle counter width: clog2(TIMEOUT_SEC+1); saturates and never wraps.
- Reset mid-edit: immediate return to RUN, load=0, no write to the counter.
- Protocol: load is never asserted outside the SET_SEC->RUN transition. Shadow fields never hold an out-of-range value.

Optional Feature:
- Macro: CLOCK_SET_AUTO_REPEAT_EN.
- When defined: in SET states, btn_inc held high without a break for REPEAT_DELAY cycles after its rising edge produces one increment, then another every REPEAT_RATE cycles while held. Repeat counter clears on btn_inc low, on any mode edge, and on state exit. Auto-increments clear the idle counter.
- When undefined: only rising edges increment; the repeat counter and parameters are unused and no logic is generated.

Decomposition:
- Package clock_set_pkg:
  - state encoding constants ST_RUN=0, ST_HOUR=1, ST_MIN=2, ST_SEC=3 (shared with sel);
  - HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59;
  - widths HOUR_W=5, MIN_W=6, SEC_W=6.
- One sub-module, btn_edge: 1-bit previous-level register plus rise output, instantiated twice.
- FSM, shadow registers, idle timer and auto-repeat stay in clock_set_ctrl.

Test Plan:
- Reset, then idle 10 sec_ticks -> cnt_en=1, sel=0, load never pulses.
- Full edit:
  - stimulus: cur=12:34:56; mode edge; 13 inc edges; mode; 26 inc; mode; 4 inc; mode;
  - response: sel steps 1,2,3,0; single load pulse with load_*=01:00:00 (hour 12+13 wraps to 1, min 34+26 wraps to 0, sec 56+4 wraps to 0); cnt_en=0 throughout the edit.
- Timeout:
  - stimulus: TIMEOUT_SEC=3; enter SET_HOUR; no buttons;
  - response: on the 3rd sec_tick, state RUN, cnt_en=1, load stays 0.
  - An inc edge after 2 ticks delays the abort to 3 ticks after that edge.
- Simultaneous mode and inc edges in SET_MIN -> state SET_SEC, load_min unchanged.
- Reset_n pulled low while in SET_SEC with edits pending -> outputs return to their reset values asynchronously; no load after release.
- AUTO_REPEAT_EN with REPEAT_DELAY=20, REPEAT_RATE=5; btn_inc held 41 cycles in SET_SEC from sec=58 -> 1 edge increment + auto-increments at cycles 20,25,30,35,40 -> final load_sec=4.

Source files
------------

// File: rtl/clock_set_pkg.sv
// Shared constants for the time-of-day set controller: state/sel encoding,
// field limits and widths, plus wrapping increment helpers for each field.
package clock_set_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  // State encoding doubles as the sel output seen by the display.
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOUR = 2'd1;
  localparam logic [1:0] ST_MIN  = 2'd2;
  localparam logic [1:0] ST_SEC  = 2'd3;

  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(23);
  localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(59);
  localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(59);

  function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
    return (h >= HOUR_MAX) ? '0 : h + HOUR_W'(1);
  endfunction

  function automatic logic [MIN_W-1:0] next_min(input logic [MIN_W-1:0] m);
    return (m >= MIN_MAX) ? '0 : m + MIN_W'(1);
  endfunction

  function automatic logic [SEC_W-1:0] next_sec(input logic [SEC_W-1:0] s);
    return (s >= SEC_MAX) ? '0 : s + SEC_W'(1);
  endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_edge.sv
// Rising-edge detector for an already synchronized, debounced button level.
module btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/set controller for an hh:mm:ss counter: gates counting, edits shadow
// copies of the time and writes them back. Optional hold-to-repeat on the
// increment button is enabled by defining CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int TIMEOUT_SEC  = 30,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sec_tick,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [SEC_W-1:0]  cur_sec,
  output logic              cnt_en,
  output logic              load,
  output logic [HOUR_W-1:0] load_hour,
  output logic [MIN_W-1:0]  load_min,
  output logic [SEC_W-1:0]  load_sec,
  output logic [1:0]        sel
);

  localparam int IDLE_W = $clog2(TIMEOUT_SEC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_SEC);

  // Out-of-range parameters leave this marker block in the elaborated tree.
  if (TIMEOUT_SEC < 1 || TIMEOUT_SEC > 255 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
  begin : g_param_out_of_range
  end

  logic              mode_rise;
  logic              inc_rise;
  logic              auto_inc;
  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [IDLE_W-1:0] idle;
  logic [IDLE_W-1:0] idle_next;
  logic [IDLE_W-1:0] idle_sat;
  logic              capture;
  logic              bump;
  logic              load_next;

  btn_edge u_mode_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (btn_mode),
    .rise    (mode_rise)
  );

  btn_edge u_inc_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (btn_inc),
    .rise    (inc_rise)
  );

  // The state register is exported directly as sel (state visibility).
  assign sel = state;

  assign idle_sat = (idle == IDLE_LIMIT) ? idle : idle + IDLE_W'(1);

  // Priority inside SET states: mode edge, then increment, then second tick.
  always_comb begin
    state_next = state;
    idle_next  = idle;
    capture    = 1'b0;
    bump       = 1'b0;
    load_next  = 1'b0;
    if (state == ST_RUN) begin
      if (mode_rise) begin
        state_next = ST_HOUR;
        capture    = 1'b1;
        idle_next  = '0;
      end
    end else if (mode_rise) begin
      idle_next = '0;
      case (state)
        ST_HOUR: state_next = ST_MIN;
        ST_MIN:  state_next = ST_SEC;
        default: begin
          state_next = ST_RUN;
          load_next  = 1'b1;
        end
      endcase
    end else if (inc_rise || auto_inc) begin
      bump      = 1'b1;
      idle_next = '0;
    end else if (sec_tick) begin
      idle_next = idle_sat;
      if (idle_sat == IDLE_LIMIT) begin
        state_next = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_RUN;
      cnt_en <= 1'b1;
      load   <= 1'b0;
      idle   <= '0;
    end else begin
      state  <= state_next;
      cnt_en <= (state_next == ST_RUN);
      load   <= load_next;
      idle   <= idle_next;
    end
  end

  // Shadow registers; capture clamps anything outside the legal range to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_hour <= '0;
      load_min  <= '0;
      load_sec  <= '0;
    end else if (capture) begin
      load_hour <= (cur_hour > HOUR_MAX) ? '0 : cur_hour;
      load_min  <= (cur_min > MIN_MAX) ? '0 : cur_min;
      load_sec  <= (cur_sec > SEC_MAX) ? '0 : cur_sec;
    end else if (bump) begin
      case (state)
        ST_HOUR: load_hour <= next_hour(load_hour);
        ST_MIN:  load_min  <= next_min(load_min);
        ST_SEC:  load_sec  <= next_sec(load_sec);
        default: ;
      endcase
    end
  end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic             holding;
  logic             armed;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_inc;

  assign rpt_inc = rpt_cnt + RPT_W'(1);

  // holding marks an unbroken press that began with an edge in a SET state;
  // armed flips the threshold from the initial delay to the repeat rate.
  assign auto_inc = holding && btn_inc && !mode_rise &&
                    (armed ? (rpt_inc == RPT_W'(REPEAT_RATE))
                           : (rpt_inc == RPT_W'(REPEAT_DELAY)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holding <= 1'b0;
      armed   <= 1'b0;
      rpt_cnt <= '0;
    end else if (!btn_inc || mode_rise || state_next == ST_RUN) begin
      holding <= 1'b0;
      armed   <= 1'b0;
      rpt_cnt <= '0;
    end else if (inc_rise) begin
      holding <= 1'b1;
      armed   <= 1'b0;
      rpt_cnt <= '0;
    end else if (holding) begin
      if (auto_inc) begin
        armed   <= 1'b1;
        rpt_cnt <= '0;
      end else begin
        rpt_cnt <= rpt_inc;
      end
    end
  end
`else
  assign auto_inc = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model of the set/edit rules and a load scoreboard.
module tb_clock_set_ctrl;

  localparam int T_SEC   = 3;
  localparam int R_DELAY = 20;
  localparam int R_RATE  = 5;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sec_tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0;
  logic [5:0] cur_sec = '0;
  logic       cnt_en;
  logic       load;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic [1:0] sel;

  int total = 0;
  int bad = 0;

  // behavioural model: mode 0=run, 1=hour, 2=min, 3=sec
  int m_state, m_h, m_mi, m_s, m_idle, m_hlen;
  bit m_pm, m_pi, m_load, m_hold;
  logic [16:0] exp_q[$];

  clock_set_ctrl #(
    .TIMEOUT_SEC  (T_SEC),
    .REPEAT_DELAY (R_DELAY),
    .REPEAT_RATE  (R_RATE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sec_tick  (sec_tick),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .cur_hour  (cur_hour),
    .cur_min   (cur_min),
    .cur_sec   (cur_sec),
    .cnt_en    (cnt_en),
    .load      (load),
    .load_hour (load_hour),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .sel       (sel)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_h = 0; m_mi = 0; m_s = 0; m_idle = 0; m_hlen = 0;
    m_pm = 0; m_pi = 0; m_load = 0; m_hold = 0;
  endtask

  task automatic model_step(input bit m, input bit i, input bit t,
                            input int ch, input int cm, input int cs);
    bit mr, ir, fire;
    mr = m && !m_pm;
    ir = i && !m_pi;
    m_pm = m;
    m_pi = i;
    fire = 0;
    m_load = 0;
    if (!i || mr) m_hold = 0;
    else if (ir && m_state != 0) begin
      m_hold = 1;
      m_hlen = 0;
    end else if (m_hold) begin
      m_hlen++;
      fire = AUTO && (m_hlen == R_DELAY ||
                      (m_hlen > R_DELAY && (m_hlen - R_DELAY) % R_RATE == 0));
    end
    if (m_state == 0) begin
      if (mr) begin
        m_state = 1;
        m_h = (ch > 23) ? 0 : ch;
        m_mi = (cm > 59) ? 0 : cm;
        m_s = (cs > 59) ? 0 : cs;
        m_idle = 0;
      end
    end else if (mr) begin
      m_idle = 0;
      if (m_state == 3) begin
        m_state = 0;
        m_load = 1;
        exp_q.push_back({5'(m_h), 6'(m_mi), 6'(m_s)});
      end else m_state++;
    end else if (ir || fire) begin
      m_idle = 0;
      case (m_state)
        1: m_h = (m_h + 1) % 24;
        2: m_mi = (m_mi + 1) % 60;
        default: m_s = (m_s + 1) % 60;
      endcase
    end else if (t) begin
      if (m_idle < T_SEC) m_idle++;
      if (m_idle >= T_SEC) m_state = 0;
    end
    if (m_state == 0) m_hold = 0;
  endtask

  // driver: inputs change on the falling edge, outputs are checked 1 ns after the rising edge
  task automatic cycle(input bit m, input bit i, input bit t);
    @(negedge clk);
    btn_mode = m;
    btn_inc = i;
    sec_tick = t;
    @(posedge clk);
    model_step(m, i, t, int'(cur_hour), int'(cur_min), int'(cur_sec));
    #1;
  endtask

  task automatic press(input bit m, input bit i);
    cycle(m, i, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    exp_q.delete();
    #1;
    total++;
    if (cnt_en !== 1'b1 || sel !== 2'd0 || load !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got cnt_en=%0b sel=%0d load=%0b exp 1 0 0", cnt_en, sel, load);
    end
    total++;
    if (load_hour !== 5'd0 || load_min !== 6'd0 || load_sec !== 6'd0) begin
      bad++;
      $display("FAIL reset_shadow got %0d:%0d:%0d exp 0:0:0", load_hour, load_min, load_sec);
    end
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      total++;
      if (cnt_en !== 1'b1 || sel !== 2'd0 || load !== 1'b0) begin
        bad++;
        $display("FAIL idle_ticks got cnt_en=%0b sel=%0d load=%0b exp 1 0 0", cnt_en, sel, load);
      end
      cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_full_edit();
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    cycle(1'b1, 1'b0, 1'b0);
    total++;
    if (sel !== 2'd1 || cnt_en !== 1'b0) begin
      bad++;
      $display("FAIL edit_enter got sel=%0d cnt_en=%0b exp 1 0", sel, cnt_en);
    end
    cycle(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 13; k++) begin
      press(1'b0, 1'b1);
      total++;
      if (cnt_en !== 1'b0 || load !== 1'b0) begin
        bad++;
        $display("FAIL edit_hour_gate got cnt_en=%0b load=%0b exp 0 0", cnt_en, load);
      end
    end
    total++;
    if (load_hour !== 5'd1) begin
      bad++;
      $display("FAIL edit_hour_wrap got %0d exp 1", load_hour);
    end
    press(1'b1, 1'b0);
    total++;
    if (sel !== 2'd2) begin
      bad++;
      $display("FAIL edit_sel_min got %0d exp 2", sel);
    end
    for (int k = 0; k < 26; k++) press(1'b0, 1'b1);
    total++;
    if (load_min !== 6'd0 || cnt_en !== 1'b0) begin
      bad++;
      $display("FAIL edit_min_wrap got min=%0d cnt_en=%0b exp 0 0", load_min, cnt_en);
    end
    press(1'b1, 1'b0);
    total++;
    if (sel !== 2'd3) begin
      bad++;
      $display("FAIL edit_sel_sec got %0d exp 3", sel);
    end
    for (int k = 0; k < 4; k++) press(1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    total++;
    if (load !== 1'b1 || sel !== 2'd0 || cnt_en !== 1'b1) begin
      bad++;
      $display("FAIL edit_commit got load=%0b sel=%0d cnt_en=%0b exp 1 0 1", load, sel, cnt_en);
    end
    total++;
    if (load_hour !== 5'd1 || load_min !== 6'd0 || load_sec !== 6'd0) begin
      bad++;
      $display("FAIL edit_values got %0d:%0d:%0d exp 1:0:0", load_hour, load_min, load_sec);
    end
    cycle(1'b0, 1'b0, 1'b0);
    total++;
    if (load !== 1'b0) begin
      bad++;
      $display("FAIL edit_load_width got %0b exp 0", load);
    end
  endtask

  task automatic test_timeout();
    press(1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      total++;
      if (sel !== ((k < 3) ? 2'd1 : 2'd0) || load !== 1'b0) begin
        bad++;
        $display("FAIL timeout_tick%0d got sel=%0d load=%0b exp %0d 0", k, sel, load, (k < 3) ? 1 : 0);
      end
      cycle(1'b0, 1'b0, 1'b0);
    end
    total++;
    if (cnt_en !== 1'b1 || load !== 1'b0) begin
      bad++;
      $display("FAIL timeout_run got cnt_en=%0b load=%0b exp 1 0", cnt_en, load);
    end
  endtask

  task automatic test_timeout_restart();
    press(1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      total++;
      if (sel !== ((k < 3) ? 2'd1 : 2'd0) || cnt_en !== (k == 3)) begin
        bad++;
        $display("FAIL restart_tick%0d got sel=%0d cnt_en=%0b exp %0d %0b", k, sel, cnt_en,
                 (k < 3) ? 1 : 0, k == 3);
      end
    end
  endtask

  task automatic test_simultaneous();
    cur_hour = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    total++;
    if (sel !== 2'd3 || load_min !== 6'd20) begin
      bad++;
      $display("FAIL simul_mode_wins got sel=%0d min=%0d exp 3 20", sel, load_min);
    end
    cycle(1'b1, 1'b0, 1'b0);
    total++;
    if (load !== 1'b1 || {load_hour, load_min, load_sec} !== {5'd10, 6'd20, 6'd30}) begin
      bad++;
      $display("FAIL simul_commit got load=%0b %0d:%0d:%0d exp 1 10:20:30", load, load_hour,
               load_min, load_sec);
    end
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_edit();
    cur_hour = 5'd7; cur_min = 6'd8; cur_sec = 6'd9;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (cnt_en !== 1'b1 || sel !== 2'd0 || load !== 1'b0 || load_sec !== 6'd0 || load_hour !== 5'd0) begin
      bad++;
      $display("FAIL async_reset got cnt_en=%0b sel=%0d load=%0b sec=%0d hour=%0d exp 1 0 0 0 0",
               cnt_en, sel, load, load_sec, load_hour);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      total++;
      if (load !== 1'b0 || cnt_en !== 1'b1) begin
        bad++;
        $display("FAIL post_reset got load=%0b cnt_en=%0b exp 0 1", load, cnt_en);
      end
    end
  endtask

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    cur_hour = 5'd0; cur_min = 6'd0; cur_sec = 6'd58;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    for (int k = 0; k < 41; k++) begin
      cycle(1'b0, 1'b1, 1'b0);
      total++;
      if (load_sec !== 6'(m_s)) begin
        bad++;
        $display("FAIL auto_step%0d got %0d exp %0d", k, load_sec, m_s);
      end
    end
    cycle(1'b0, 1'b0, 1'b0);
    total++;
    if (load_sec !== 6'd4) begin
      bad++;
      $display("FAIL auto_final got %0d exp 4", load_sec);
    end
    cycle(1'b1, 1'b0, 1'b0);
    total++;
    if (load !== 1'b1 || load_sec !== 6'd4) begin
      bad++;
      $display("FAIL auto_commit got load=%0b sec=%0d exp 1 4", load, load_sec);
    end
    cycle(1'b0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_random();
    int hold_left;
    bit m, i, t;
    logic [16:0] exp_w;
    hold_left = 0;
    exp_q.delete();
    for (int n = 0; n < 3000; n++) begin
      m = ($urandom_range(0, 15) == 0);
      if (hold_left > 0) begin
        i = 1'b1;
        hold_left--;
      end else if ($urandom_range(0, 3) == 0) begin
        i = 1'b1;
        hold_left = $urandom_range(0, 30);
      end else i = 1'b0;
      t = ($urandom_range(0, 9) == 0);
      cur_hour = 5'($urandom_range(0, 23));
      cur_min = 6'($urandom_range(0, 59));
      cur_sec = 6'($urandom_range(0, 59));
      cycle(m, i, t);
      total++;
      if (sel !== 2'(m_state) || cnt_en !== (m_state == 0) || load !== m_load) begin
        bad++;
        $display("FAIL rand_ctrl n=%0d got sel=%0d cnt_en=%0b load=%0b exp %0d %0b %0b", n, sel,
                 cnt_en, load, m_state, m_state == 0, m_load);
      end
      total++;
      if (load_hour !== 5'(m_h) || load_min !== 6'(m_mi) || load_sec !== 6'(m_s)) begin
        bad++;
        $display("FAIL rand_shadow n=%0d got %0d:%0d:%0d exp %0d:%0d:%0d", n, load_hour, load_min,
                 load_sec, m_h, m_mi, m_s);
      end
      if (load === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rand_load_unexpected n=%0d got load=1 exp none", n);
        end else begin
          exp_w = exp_q.pop_front();
          if ({load_hour, load_min, load_sec} !== exp_w) begin
            bad++;
            $display("FAIL rand_load_value n=%0d got %0h exp %0h", n,
                     {load_hour, load_min, load_sec}, exp_w);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_load_missing got pending=%0d exp 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_edit();
    test_timeout();
    test_timeout_restart();
    test_simultaneous();
    test_reset_mid_edit();
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
